// File: rtl/imem_boot_loader_pkg.sv
// loader_pkg: constants shared by the instruction-memory boot loader and
// its byte-to-word assembler.
//   - FSM state encodings
//   - default instruction width, bytes per stream word and frame sync marker
package loader_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEN   = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_CHK   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERROR = 3'd5;

   localparam int         LOADER_INSTR_W    = 49;
   localparam int         LOADER_WORD_BYTES = 7;
   localparam logic [7:0] LOADER_SYNC_BYTE  = 8'hA5;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// loader_word_assembler: collects WORD_BYTES little-endian bytes into one
// instruction word.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   clear          frame start; drops any partial word
//   shift_en       accept byte_in as the next byte of the current word
//   byte_in        stream byte
//   word_valid     combinational pulse: byte_in completes a word this cycle
//   word           assembled word (valid with word_valid), upper bytes beyond INSTR_W dropped
module loader_word_assembler
   import loader_pkg::*;
#(
   parameter int INSTR_W    = LOADER_INSTR_W,
   parameter int WORD_BYTES = LOADER_WORD_BYTES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               shift_en,
   input  logic [7:0]         byte_in,
   output logic               word_valid,
   output logic [INSTR_W-1:0] word
);

   localparam int SR_W  = (WORD_BYTES - 1) * 8;
   localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   logic [CNT_W-1:0]  cnt;
   logic [SR_W-1:0]   sr;
   logic [SR_W+7:0]   word_full;

   // The final byte is used straight from the input so the word is ready
   // on the same edge that accepts it.
   assign word_full  = {byte_in, sr};
   assign word_valid = shift_en && (cnt == CNT_W'(WORD_BYTES - 1));
   assign word       = INSTR_W'(word_full);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
         sr  <= '0;
      end else if (shift_en) begin
         sr  <= word_full[SR_W+7:8];
         cnt <= word_valid ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: writes a framed byte stream into instruction memory and
// holds the CPU in reset until a complete, valid image is loaded.
// Frame: SYNC, LEN (word count), LEN*WORD_BYTES data bytes, [CHK].
// Build option: define CHECKSUM_EN to require a trailing XOR-of-data byte.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_data    byte stream in; in_ready is the accept handshake
//   mem_we/addr/din     instruction memory write port (one-cycle strobe)
//   cpu_hold            1 = keep CPU in reset
//   load_done/load_err  frame accepted / frame rejected
//   words_loaded        words written in current or last frame
//
// state | meaning
// IDLE  | waiting for SYNC, other bytes dropped
// LEN   | next byte is the word count
// DATA  | assembling and writing words
// CHK   | next byte must equal XOR of data bytes (CHECKSUM_EN only)
// DONE  | image accepted, CPU released; SYNC restarts
// ERROR | frame rejected, CPU held; SYNC restarts
module imem_boot_loader
   import loader_pkg::*;
#(
   parameter int         ADDR_W     = 6,
   parameter int         INSTR_W    = LOADER_INSTR_W,
   parameter int         WORD_BYTES = LOADER_WORD_BYTES,
   parameter logic [7:0] SYNC_BYTE  = LOADER_SYNC_BYTE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_din,
   output logic               cpu_hold,
   output logic               load_done,
   output logic               load_err,
   output logic [ADDR_W:0]    words_loaded
);

   logic [2:0]         state;
   logic [ADDR_W:0]    words_left;
   logic [ADDR_W-1:0]  word_addr;
   logic               accept;
   logic               frame_start;
   logic               data_shift;
   logic               len_ok;
   logic               word_valid;
   logic [INSTR_W-1:0] word;

   assign accept      = in_valid && in_ready;
   assign frame_start = accept && (in_data == SYNC_BYTE) &&
                        ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
   assign data_shift  = accept && (state == ST_DATA);
   assign len_ok      = (in_data != 8'd0) && ({1'b0, in_data} <= 9'(2 ** ADDR_W));

   loader_word_assembler #(
      .INSTR_W    (INSTR_W),
      .WORD_BYTES (WORD_BYTES)
   ) u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (frame_start),
      .shift_en   (data_shift),
      .byte_in    (in_data),
      .word_valid (word_valid),
      .word       (word)
   );

`ifdef CHECKSUM_EN
   logic [7:0] chk_acc;

   always_ff @(posedge clk) begin
      if (reset || frame_start) begin
         chk_acc <= '0;
      end else if (data_shift) begin
         chk_acc <= chk_acc ^ in_data;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         in_ready     <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_din      <= '0;
         cpu_hold     <= 1'b1;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= '0;
         words_left   <= '0;
         word_addr    <= '0;
      end else begin
         in_ready <= 1'b1;
         mem_we   <= 1'b0;

         // Word address wraps to 0 after a full 2**ADDR_W image; no write follows.
         if (word_valid) begin
            mem_we       <= 1'b1;
            mem_din      <= word;
            mem_addr     <= word_addr;
            word_addr    <= word_addr + ADDR_W'(1);
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
            words_left   <= words_left - (ADDR_W+1)'(1);
         end

         if (frame_start) begin
            state        <= ST_LEN;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_LEN: begin
                  if (accept) begin
                     if (len_ok) begin
                        words_left <= (ADDR_W+1)'(in_data);
                        word_addr  <= '0;
                        state      <= ST_DATA;
                     end else begin
                        state <= ST_ERROR;
                     end
                  end
               end
               ST_DATA: begin
                  if (word_valid && (words_left == (ADDR_W+1)'(1))) begin
`ifdef CHECKSUM_EN
                     state <= ST_CHK;
`else
                     state <= ST_DONE;
`endif
                  end
               end
               ST_CHK: begin
`ifdef CHECKSUM_EN
                  if (accept) begin
                     state <= (in_data == chk_acc) ? ST_DONE : ST_ERROR;
                  end
`else
                  state <= ST_ERROR;
`endif
               end
               ST_DONE: begin
                  load_done <= 1'b1;
                  cpu_hold  <= 1'b0;
               end
               ST_ERROR: begin
                  load_err <= 1'b1;
                  cpu_hold <= 1'b1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
